// File: rtl/seq_shifter_pkg.sv
// Shared types and constants for the multi-cycle shift/rotate unit.
// Holds the FSM state encoding and the direction codes.
package seq_shifter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/seq_shifter_shift_step.sv
// One-bit shift/rotate step; purely combinational, zero latency.
// No backpressure: the result is a pure function of the inputs.
module shift_step
    import seq_shifter_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] value,
    input  logic             dir,
    input  logic             rotate,
    input  logic             fill,
    output logic [WIDTH-1:0] next_value,
    output logic             out_bit
);

    logic ins;

    always_comb begin
        out_bit = (dir == DIR_RIGHT) ? value[0] : value[WIDTH-1];
        // Rotate re-inserts the bit that just left; logical mode inserts fill.
        ins     = rotate ? out_bit : fill;
        if (dir == DIR_RIGHT) begin
            next_value = {ins, value[WIDTH-1:1]};
        end else begin
            next_value = {value[WIDTH-2:0], ins};
        end
    end

endmodule

// File: rtl/seq_shifter.sv
// Multi-cycle shifter: one bit per enabled clock, done = start + amt + 1 cycles.
// Backpressure: en=0 stalls the shift; start is ignored while busy.
module seq_shifter
    import seq_shifter_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int AMT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] din,
    input  logic [AMT_W-1:0] amt,
    input  logic             dir,
    input  logic             rotate,
    input  logic             fill,
    input  logic             en,
    output logic [WIDTH-1:0] dout,
    output logic             shift_out,
    output logic             busy,
    output logic             done
);

    if (WIDTH < 2) begin : g_bad_width
        $error("seq_shifter: WIDTH must be at least 2");
    end
    if (AMT_W != $clog2(WIDTH)) begin : g_bad_amt_w
        $error("seq_shifter: AMT_W must equal clog2(WIDTH)");
    end

    state_t           state;
    logic [AMT_W-1:0] cnt;
    logic             dir_q;
    logic             rotate_q;
    logic             fill_q;

    logic [WIDTH-1:0] step_value;
    logic             step_out;

    shift_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .value      (dout),
        .dir        (dir_q),
        .rotate     (rotate_q),
        .fill       (fill_q),
        .next_value (step_value),
        .out_bit    (step_out)
    );

    // busy and done are kept as registers that track the state transitions,
    // so they equal (state != IDLE) and (state == DONE) without output decode.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            dir_q     <= DIR_LEFT;
            rotate_q  <= 1'b0;
            fill_q    <= 1'b0;
            dout      <= '0;
            shift_out <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        dout      <= din;
                        cnt       <= amt;
                        dir_q     <= dir;
                        rotate_q  <= rotate;
                        fill_q    <= fill;
                        shift_out <= 1'b0;
                        busy      <= 1'b1;
                        if (amt != '0) begin
                            state <= SHIFT;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    if (en) begin
                        dout      <= step_value;
                        shift_out <= step_out;
                        cnt       <= cnt - 1'b1;
                        if (cnt == AMT_W'(1)) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_shifter.sv
// Bench for seq_shifter: directed scenarios plus random operations
// checked against a closed-form shift/rotate reference.
module tb_seq_shifter;

    localparam int W  = 8;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [W-1:0]  din;
    logic [AW-1:0] amt;
    logic          dir;
    logic          rotate;
    logic          fill;
    logic          en;
    logic [W-1:0]  dout;
    logic          shift_out;
    logic          busy;
    logic          done;

    int n_tests = 0;
    int n_fail  = 0;

    seq_shifter #(.WIDTH(W), .AMT_W(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .din       (din),
        .amt       (amt),
        .dir       (dir),
        .rotate    (rotate),
        .fill      (fill),
        .en        (en),
        .dout      (dout),
        .shift_out (shift_out),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Result of shifting x by a positions, written as whole-word arithmetic.
    function automatic void ref_model(input logic [W-1:0] x, input int a, input bit d,
                                      input bit r, input bit f,
                                      output logic [W-1:0] res, output bit so);
        int xi, mask, ri;
        xi   = int'(x);
        mask = (1 << W) - 1;
        if (a == 0) begin
            ri = xi;
            so = 1'b0;
        end else if (r) begin
            if (d) ri = ((xi >> a) | (xi << (W - a))) & mask;
            else   ri = ((xi << a) | (xi >> (W - a))) & mask;
            // After a rotate the last bit out is also the last bit in.
            so = d ? ri[W-1] : ri[0];
        end else if (d) begin
            ri = (xi >> a) | (f ? (mask & ~(mask >> a)) : 0);
            so = xi[a-1];
        end else begin
            ri = ((xi << a) & mask) | (f ? ((1 << a) - 1) : 0);
            so = xi[W-a];
        end
        res = ri[W-1:0];
    endfunction

    task automatic run_op(input logic [W-1:0] x, input int a, input bit d, input bit r,
                          input bit f, input bit rand_en, input logic [31:0] en_pat,
                          input bit junk);
        int cyc, stalls, idx;
        bit got_done;
        logic [W-1:0] exp_val;
        bit exp_so;
        @(negedge clk);
        start  = 1'b1;
        din    = x;
        amt    = a[AW-1:0];
        dir    = d;
        rotate = r;
        fill   = f;
        en     = 1'b1;
        cyc = 0; stalls = 0; idx = 0; got_done = 1'b0;
        while (cyc < 64 && !got_done) begin
            @(negedge clk);
            cyc++;
            start  = junk ? 1'($urandom_range(1)) : 1'b0;
            din    = W'($urandom);
            amt    = AW'($urandom);
            dir    = 1'($urandom);
            rotate = 1'($urandom);
            fill   = 1'($urandom);
            check("busy_during_op", busy, 1);
            if (done) begin
                got_done = 1'b1;
            end else begin
                en = rand_en ? ($urandom_range(3) != 0) : ((idx < 32) ? en_pat[idx] : 1'b1);
                idx++;
                if (!en) stalls++;
            end
        end
        check("done_seen", got_done, 1);
        check("latency", cyc, a + 1 + stalls);
        ref_model(x, a, d, r, f, exp_val, exp_so);
        check("dout", dout, exp_val);
        check("shift_out", shift_out, exp_so);
        @(negedge clk);
        start = 1'b0;
        check("idle_busy", busy, 0);
        check("idle_done", done, 0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; din = '0; amt = '0;
        dir = 1'b0; rotate = 1'b0; fill = 1'b0; en = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_dout", dout, 0);
        check("rst_shift_out", shift_out, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        rst_n = 1'b1;

        run_op(8'hB1, 3, 1'b0, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b0);
        run_op(8'hA5, 4, 1'b1, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b0);
        run_op(8'h3C, 0, 1'b0, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b0);
        run_op(8'h01, 2, 1'b0, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFF1, 1'b1);
        run_op(8'h80, 7, 1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b0);

        // Abort an operation with reset part-way through.
        @(negedge clk);
        start = 1'b1; din = 8'h5A; amt = 3'd5; dir = 1'b0; rotate = 1'b0; fill = 1'b1; en = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("abort_busy_t1", busy, 1);
        @(negedge clk);
        check("abort_done_t2", done, 0);
        @(negedge clk);
        check("abort_done_t3", done, 0);
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("abort_dout", dout, 0);
            check("abort_busy", busy, 0);
            check("abort_done", done, 0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        check("post_abort_done", done, 0);
        check("post_abort_busy", busy, 0);
        run_op(8'hB1, 3, 1'b0, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b0);

        for (int i = 0; i < 40; i++) begin
            run_op(W'($urandom), int'($urandom_range(W - 1)), 1'($urandom), 1'($urandom),
                   1'($urandom), 1'b1, 32'hFFFF_FFFF, 1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_shifter.md
Name: seq_shifter

Overview:
Parametrised, multi-cycle shift/rotate unit; next generation of the team's fixed 4-bit combinational shifter.
- Captures an operand on a start handshake and shifts it one bit position per enabled clock, for a programmable count.
- Supports left/right, logical-with-fill or rotate.
- Reports completion with a one-cycle done pulse and exposes the last bit shifted out.
- Sits in the datapath alongside the ALU as the shift execution unit.

Parameters:
- WIDTH, 8: operand width in bits; legal range is at least 2.
- AMT_W, 3: width of the shift-amount port. Must equal clog2(WIDTH); elaboration fails otherwise.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset
- start  in  1  request; sampled only while busy=0
- din  in  WIDTH  operand, captured on accepted start
- amt  in  AMT_W  shift count 0..WIDTH-1, captured on accepted start
- dir  in  1  0 = left (toward MSB), 1 = right; captured on start
- rotate  in  1  1 = rotate, 0 = logical shift with fill; captured on start
- fill  in  1  bit inserted at vacated end when rotate=0; captured on start
- en  in  1  step enable; 0 stalls the shift without losing state
- dout  out  WIDTH  working register; final result is valid while done=1
- shift_out  out  1  last bit shifted or rotated out of the vacated end
- busy  out  1  high from the cycle after an accepted start through the done cycle
- done  out  1  one-cycle completion pulse

Behaviour:
- Reset: one clock is synchronous, and reset is synchronous and active-low (clk, rst_n). While rst_n=0 at a rising edge:
  - state goes to IDLE; dout=0, shift_out=0, busy=0, done=0.
  - Reset mid-operation aborts the operation; no done pulse is issued.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE, start=1: load dout<=din, cnt<=amt, and latch dir, rotate and fill. Clear shift_out<=0. Next state is SHIFT if amt!=0, else DONE.
  - SHIFT, en=1: perform one step and decrement cnt. If cnt==1 before the decrement, next state is DONE.
  - SHIFT, en=0: hold all registers.
  - DONE: done=1 for exactly one cycle, then IDLE. en is ignored.
- Outputs:
  - busy = (state != IDLE).
  - start while busy=1 is ignored, including in the DONE cycle. din, amt and the mode inputs are don't-care after capture.
- One step, with W = WIDTH:
  - Left: shift_out<=dout[W-1]; dout<={dout[W-2:0], ins}.
  - Right: shift_out<=dout[0]; dout<={ins, dout[W-1:1]}.
  - ins = rotate ? (the bit shifted out) : fill.
- Latency: with start accepted in cycle t and en held high, done=1 in cycle t+amt+1. Each en=0 cycle in SHIFT adds one cycle. amt=0 gives done in t+1 with dout=din and shift_out=0.
- Back-to-back: earliest next accept is the cycle after done (IDLE).
- No combinational path from inputs to outputs; all outputs are registered or decoded from the state register.

Decomposition:
- Shared package seq_shifter_pkg:
  - state enum typedef (IDLE, SHIFT, DONE);
  - constants DIR_LEFT=0, DIR_RIGHT=1.
- One natural sub-module: shift_step. It is a combinational single-bit step with inputs value, dir, rotate and fill, and outputs next value and out bit. It is instantiated once in seq_shifter; the FSM, counter and registers stay in the top.

Test Plan (WIDTH=8):
1. Left logical: din=8'hB1, amt=3, dir=0, rotate=0, fill=1, en=1.
   -> busy rises at t+1; done only at t+4; dout=8'h8F, shift_out=1.
2. Right rotate: din=8'hA5, amt=4, dir=1, rotate=1.
   -> done at t+5; dout=8'h5A, shift_out=0.
3. Zero amount: din=8'h3C, amt=0.
   -> done at t+1; dout=8'h3C, shift_out=0; busy high only in t+1.
4. Stall and ignored start: din=8'h01, amt=2, dir=0, rotate=0, fill=0. Drive en=0 for 3 cycles after the first step, and pulse start with din=8'hFF while busy.
   -> done at t+6; dout=8'h04; the second start has no effect.
5. Full-width right logical: din=8'h80, amt=7, dir=1, rotate=0, fill=0.
   -> done at t+8; dout=8'h01, shift_out=0.
6. Reset mid-operation: start amt=5, then rst_n=0 for 2 cycles at t+3.
   -> dout=0, busy=0, done never pulses. A new start after release behaves as in scenario 1.
